// File: rtl/red_pitaya_iq_nco_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | red_pitaya_iq_nco_pkg                                              |
// | Shared NCO widths and quarter-wave table generator.                |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package red_pitaya_iq_nco_pkg;

  localparam int  c_nco_phasebits = 32;
  localparam int  c_nco_lutbits   = 11;
  localparam int  c_nco_sinbits   = 14;
  localparam real c_pi            = 3.14159265358979323846;

  // Entry k samples the centre of its bin so a mirrored read (~k) is exactly cos.
  // A plain Taylor series keeps this a pure elaboration-time constant function.
  function automatic int nco_quarter_sin(input int k, input int lutbits, input int sinbits);
    real x;
    real term;
    real sum;
    x    = 2.0 * c_pi * (real'(k) + 0.5) / real'(2 ** (lutbits + 2));
    term = x;
    sum  = x;
    for (int n = 1; n < 14; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return $rtoi(real'((2 ** (sinbits - 1)) - 1) * sum + 0.5);
  endfunction

endpackage
`default_nettype wire

// File: rtl/red_pitaya_iq_nco_lut.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | red_pitaya_iq_nco_lut                                              |
// | Quarter-wave sine ROM with two registered read ports.              |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module red_pitaya_iq_nco_lut
  import red_pitaya_iq_nco_pkg::*;
#(
  parameter int LUTBITS = c_nco_lutbits,
  parameter int SINBITS = c_nco_sinbits
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [LUTBITS-1:0] addr_a_i,
  input  logic [LUTBITS-1:0] addr_b_i,
  output logic [SINBITS-2:0] data_a_o,
  output logic [SINBITS-2:0] data_b_o
);

  localparam int c_depth = 2 ** LUTBITS;

  logic [SINBITS-2:0] rom [c_depth];

  for (genvar gi = 0; gi < c_depth; gi++) begin : g_rom
    localparam int c_val = nco_quarter_sin(gi, LUTBITS, SINBITS);
    assign rom[gi] = c_val[SINBITS-2:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_a_o <= '0;
      data_b_o <= '0;
    end else begin
      data_a_o <= rom[addr_a_i];
      data_b_o <= rom[addr_b_i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/red_pitaya_iq_nco_block.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | red_pitaya_iq_nco_block                                            |
// | Phase-accumulator NCO producing registered sin/cos and wrap pulse. |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module red_pitaya_iq_nco_block
  import red_pitaya_iq_nco_pkg::*;
#(
  parameter int PHASEBITS = c_nco_phasebits,
  parameter int LUTBITS   = c_nco_lutbits,
  parameter int SINBITS   = c_nco_sinbits
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [PHASEBITS-1:0]      freq_i,
  input  logic [PHASEBITS-1:0]      phase_i,
  input  logic                      sync_i,
  output logic signed [SINBITS-1:0] sin_o,
  output logic signed [SINBITS-1:0] cos_o,
  output logic                      wrap_o
);

  logic [PHASEBITS-1:0]      r_acc;
  logic [PHASEBITS-1:0]      r_ph;
  logic                      r_wrap0;
  logic                      r_wrap1;
  logic                      r_wrap2;
  logic [1:0]                r_quad;
  logic [PHASEBITS:0]        w_sum;
  logic [1:0]                w_quad;
  logic [LUTBITS-1:0]        w_k;
  logic [LUTBITS-1:0]        w_addr_s;
  logic [LUTBITS-1:0]        w_addr_c;
  logic [SINBITS-2:0]        w_amp_s;
  logic [SINBITS-2:0]        w_amp_c;
  logic signed [SINBITS-1:0] w_sin_pos;
  logic signed [SINBITS-1:0] w_cos_pos;

  assign w_sum    = {1'b0, r_acc} + {1'b0, freq_i};
  assign w_quad   = r_ph[PHASEBITS-1 -: 2];
  assign w_k      = r_ph[PHASEBITS-3 -: LUTBITS];
  assign w_addr_s = w_quad[0] ? ~w_k : w_k;
  assign w_addr_c = w_quad[0] ? w_k : ~w_k;

  if (PHASEBITS > LUTBITS + 2) begin : g_trunc
    logic w_unused_lsb;
    assign w_unused_lsb = ^r_ph[PHASEBITS-LUTBITS-3:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_acc   <= '0;
      r_wrap0 <= 1'b0;
      r_ph    <= '0;
      r_wrap1 <= 1'b0;
      r_quad  <= '0;
      r_wrap2 <= 1'b0;
    end else begin
      r_acc   <= sync_i ? '0 : w_sum[PHASEBITS-1:0];
      r_wrap0 <= ~sync_i & w_sum[PHASEBITS];
      r_ph    <= r_acc + phase_i;
      r_wrap1 <= r_wrap0;
      r_quad  <= w_quad;
      r_wrap2 <= r_wrap1;
    end
  end

  red_pitaya_iq_nco_lut #(
    .LUTBITS (LUTBITS),
    .SINBITS (SINBITS)
  ) u_lut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .addr_a_i (w_addr_s),
    .addr_b_i (w_addr_c),
    .data_a_o (w_amp_s),
    .data_b_o (w_amp_c)
  );

  // Table magnitude tops out at 2^(SINBITS-1)-1, so negation never overflows.
  assign w_sin_pos = signed'({1'b0, w_amp_s});
  assign w_cos_pos = signed'({1'b0, w_amp_c});

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sin_o  <= '0;
      cos_o  <= '0;
      wrap_o <= 1'b0;
    end else begin
      sin_o  <= r_quad[1] ? -w_sin_pos : w_sin_pos;
      cos_o  <= (r_quad[1] ^ r_quad[0]) ? -w_cos_pos : w_cos_pos;
      wrap_o <= r_wrap2;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_red_pitaya_iq_nco_block.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_red_pitaya_iq_nco_block                                         |
// | Directed vector table plus reset, wrap and sweep sequences.        |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tb_red_pitaya_iq_nco_block;

  localparam logic [31:0] c_f30 = 32'h4000_0000;
  localparam logic [31:0] c_f31 = 32'h8000_0000;

  logic               clk_i   = 1'b0;
  logic               rst_i   = 1'b1;
  logic               sync_i  = 1'b0;
  logic [31:0]        freq_i  = '0;
  logic [31:0]        phase_i = '0;
  logic signed [13:0] sin_o;
  logic signed [13:0] cos_o;
  logic               wrap_o;

  int n_checks = 0;
  int n_errors = 0;

  red_pitaya_iq_nco_block #(
    .PHASEBITS (32),
    .LUTBITS   (11),
    .SINBITS   (14)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .freq_i  (freq_i),
    .phase_i (phase_i),
    .sync_i  (sync_i),
    .sin_o   (sin_o),
    .cos_o   (cos_o),
    .wrap_o  (wrap_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        sync;
    logic [31:0] freq;
    logic [31:0] phase;
    int          s;
    int          c;
    int          w;
  } vec_t;

  vec_t vecs [26];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int es, input int ec, input int ew);
    check({tag, " sin"}, int'(sin_o), es);
    check({tag, " cos"}, int'(cos_o), ec);
    check({tag, " wrap"}, int'(wrap_o), ew);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Carry model: wrap_o must follow the carry of acc+freq three edges later.
  task automatic run_wrap(input logic [31:0] f, input int n);
    longint m_acc;
    longint s;
    bit     h[3];
    bit     w;
    bit     e;
    m_acc   = 0;
    h       = '{1'b0, 1'b0, 1'b0};
    freq_i  = f;
    phase_i = '0;
    sync_i  = 1'b1;
    for (int i = 0; i < n + 4; i++) begin
      if (i == 4) sync_i = 1'b0;
      step();
      s     = m_acc + longint'(f);
      w     = !sync_i && (s >= 64'sh1_0000_0000);
      e     = h[2];
      h[2]  = h[1];
      h[1]  = h[0];
      h[0]  = w;
      m_acc = sync_i ? 0 : (s & 64'sh0_FFFF_FFFF);
      if (i >= 3) check($sformatf("wrap f=%h i=%0d", f, i), int'(wrap_o), int'(e));
    end
  endtask

  task automatic run_sweep(input logic [31:0] f, input int n);
    longint acc_h[4];
    real    ang, es, ec, err, max_err, pw, dev, max_dev;
    int     neg_full;
    max_err  = 0.0;
    max_dev  = 0.0;
    neg_full = 0;
    freq_i   = f;
    phase_i  = '0;
    sync_i   = 1'b1;
    step();
    sync_i   = 1'b0;
    acc_h    = '{0, 0, 0, 0};
    for (int i = 0; i < n; i++) begin
      step();
      acc_h[3] = acc_h[2];
      acc_h[2] = acc_h[1];
      acc_h[1] = acc_h[0];
      acc_h[0] = (acc_h[0] + longint'(f)) & 64'sh0_FFFF_FFFF;
      if (i >= 2) begin
        ang = 2.0 * 3.14159265358979323846 * real'(acc_h[3]) / 4294967296.0;
        es  = 8191.0 * $sin(ang);
        ec  = 8191.0 * $cos(ang);
        err = (real'(sin_o) > es) ? real'(sin_o) - es : es - real'(sin_o);
        if (err > max_err) max_err = err;
        err = (real'(cos_o) > ec) ? real'(cos_o) - ec : ec - real'(cos_o);
        if (err > max_err) max_err = err;
        pw  = real'(sin_o) * real'(sin_o) + real'(cos_o) * real'(cos_o);
        dev = (pw > 67092481.0) ? pw - 67092481.0 : 67092481.0 - pw;
        if (dev > max_dev) max_dev = dev;
        if (int'(sin_o) == -8192 || int'(cos_o) == -8192) neg_full++;
      end
    end
    // Half-bin phase truncation (pi/8192 rad * 8191) plus rounding stays under 4 LSB.
    n_checks++;
    if (max_err > 4.0) begin
      n_errors++;
      $display("FAIL sweep_err f=%h: max error %f LSB, limit 4", f, max_err);
    end
    n_checks++;
    if (max_dev > 67092.481) begin
      n_errors++;
      $display("FAIL sweep_power f=%h: max deviation %f, limit 67092.481", f, max_dev);
    end
    check($sformatf("sweep_no_neg_full f=%h", f), neg_full, 0);
  endtask

  initial begin
    // Quarter-turn steps from reset: sync once, then 2^30 per edge.
    vecs[0]  = '{1'b1, c_f30, 32'h0,    0,     0, 0};
    vecs[1]  = '{1'b0, c_f30, 32'h0,    3,  8191, 0};
    vecs[2]  = '{1'b0, c_f30, 32'h0,    3,  8191, 0};
    vecs[3]  = '{1'b0, c_f30, 32'h0,    3,  8191, 0};
    vecs[4]  = '{1'b0, c_f30, 32'h0, 8191,    -3, 0};
    vecs[5]  = '{1'b0, c_f30, 32'h0,   -3, -8191, 0};
    vecs[6]  = '{1'b0, c_f30, 32'h0, -8191,    3, 0};
    vecs[7]  = '{1'b0, c_f30, 32'h0,    3,  8191, 1};
    vecs[8]  = '{1'b0, c_f30, 32'h0, 8191,    -3, 0};
    vecs[9]  = '{1'b0, c_f30, 32'h0,   -3, -8191, 0};
    vecs[10] = '{1'b0, c_f30, 32'h0, -8191,    3, 0};
    vecs[11] = '{1'b0, c_f30, 32'h0,    3,  8191, 1};
    // Held sync with a half-turn phase offset.
    vecs[12] = '{1'b1, 32'h0, c_f31, 8191,    -3, 0};
    vecs[13] = '{1'b1, 32'h0, c_f31,   -3, -8191, 0};
    vecs[14] = '{1'b1, 32'h0, c_f31, 8191,    -3, 0};
    vecs[15] = '{1'b1, 32'h0, c_f31,   -3, -8191, 0};
    vecs[16] = '{1'b1, 32'h0, c_f31,   -3, -8191, 0};
    vecs[17] = '{1'b1, 32'h0, c_f31,   -3, -8191, 0};
    // Sync colliding with a non-zero increment, then free run.
    vecs[18] = '{1'b1, c_f30, 32'h0,   -3, -8191, 0};
    vecs[19] = '{1'b0, c_f30, 32'h0,   -3, -8191, 0};
    vecs[20] = '{1'b0, c_f30, 32'h0,    3,  8191, 0};
    vecs[21] = '{1'b0, c_f30, 32'h0,    3,  8191, 0};
    vecs[22] = '{1'b0, c_f30, 32'h0, 8191,    -3, 0};
    vecs[23] = '{1'b0, c_f30, 32'h0,   -3, -8191, 0};
    vecs[24] = '{1'b0, c_f30, 32'h0, -8191,    3, 0};
    vecs[25] = '{1'b0, c_f30, 32'h0,    3,  8191, 1};

    step();
    step();
    check_out("reset_state", 0, 0, 0);
    rst_i = 1'b0;

    for (int i = 0; i < 26; i++) begin
      sync_i  = vecs[i].sync;
      freq_i  = vecs[i].freq;
      phase_i = vecs[i].phase;
      step();
      check_out($sformatf("vec%0d", i), vecs[i].s, vecs[i].c, vecs[i].w);
    end

    run_wrap(32'h8000_0001, 12);
    run_wrap(32'hFFFF_FFFF, 12);
    run_wrap(32'hC000_0000, 12);

    run_sweep(32'd12345, 10000);
    run_sweep(32'h0123_4567, 5000);

    // Asynchronous reset mid-run, then restart from phase 0.
    sync_i  = 1'b0;
    phase_i = '0;
    freq_i  = 32'h1000_0000;
    repeat (10) step();
    #2 rst_i = 1'b1;
    #1 check_out("rst_async", 0, 0, 0);
    step();
    check_out("rst_hold", 0, 0, 0);
    rst_i = 1'b0;
    step();
    check_out("rel1", 0, 0, 0);
    step();
    check_out("rel2", 3, 8191, 0);
    step();
    check_out("rel3", 3, 8191, 0);
    step();
    check_out("rel4", 3137, 7566, 0);
    step();
    check_out("rel5", 5794, 5790, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/red_pitaya_iq_nco_block.md
RED_PITAYA_IQ_NCO_BLOCK -- requirements
Module: red_pitaya_iq_nco_block

Interface
REQ-001 SHALL have parameter PHASEBITS, default 32: phase accumulator width.
REQ-002 SHALL have parameter LUTBITS, default 11: quarter-wave table address width (2^LUTBITS entries).
REQ-003 SHALL have parameter SINBITS, default 14: signed sin/cos output width.
REQ-004 SHALL have port clk_i, input, 1: sole clock, all logic on rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port freq_i, input, PHASEBITS: unsigned phase increment per cycle.
REQ-007 SHALL have port phase_i, input, PHASEBITS: unsigned phase offset added after the accumulator.
REQ-008 SHALL have port sync_i, input, 1: synchronous accumulator clear.
REQ-009 SHALL have port sin_o, output, SINBITS: signed sine, registered.
REQ-010 SHALL have port cos_o, output, SINBITS: signed cosine, registered.
REQ-011 SHALL have port wrap_o, output, 1: one-cycle pulse marking accumulator wrap, aligned with sin_o/cos_o.

Function
REQ-012 SHALL update accumulator each edge: acc <= sync_i ? 0 : (acc + freq_i) mod 2^PHASEBITS; sync_i has priority over increment.
REQ-013 SHALL flag carry: wrap0 <= (~sync_i) & carry-out of acc + freq_i; sync_i never generates wrap.
REQ-014 SHALL compute stage 1: ph <= (acc + phase_i) mod 2^PHASEBITS; wrap1 <= wrap0.
REQ-015 SHALL split ph: q = ph[PHASEBITS-1:PHASEBITS-2] (quadrant), k = ph[PHASEBITS-3:PHASEBITS-LUTBITS-2]; lower bits truncated, no dithering.
REQ-016 SHALL hold table L[k] = round((2^(SINBITS-1)-1) * sin(2*pi*(k+0.5)/2^(LUTBITS+2))), unsigned, SINBITS-1 bits.
REQ-017 SHALL compute stage 2 (synchronous ROM, two read ports): a_s <= L[q[0] ? ~k : k], a_c <= L[q[0] ? k : ~k]; quadrant bits and wrap delayed alongside.
REQ-018 SHALL compute stage 3: sin_o <= q[1] ? -a_s : a_s; cos_o <= (q[1]^q[0]) ? -a_c : a_c; wrap_o <= wrap2.
REQ-019 SHALL never output -2^(SINBITS-1); magnitude bounded by 2^(SINBITS-1)-1, negation exact, no saturation logic needed.
REQ-020 SHALL have latency 3 edges from accumulator value to outputs: value held in acc after edge n appears on sin_o/cos_o after edge n+3, combined with phase_i sampled at edge n+1.
REQ-021 SHALL apply freq_i changes without glitch: new increment affects acc at next edge, phase continuous.
REQ-022 SHALL apply phase_i changes as an immediate phase step, visible 2 edges later.
REQ-023 SHALL hold sync_i continuously high -> acc stays 0, outputs settle to constant sin(phase_i), cos(phase_i), wrap_o 0.
REQ-024 SHALL produce wrap_o high on every cycle in which a carry occurs, including back-to-back cycles when freq_i >= 2^(PHASEBITS-1).

Reset
REQ-025 SHALL, while rst_i high, clear acc, ph, all pipeline registers, sin_o, cos_o, wrap_o to 0 asynchronously.
REQ-026 SHALL, after rst_i deasserts mid-operation, restart from acc=0 with no residual pipeline data; first valid samples after 3 edges.
REQ-027 SHALL not reset ROM contents.

Structure
REQ-028 SHALL place the quarter-wave ROM in sub-module red_pitaya_iq_nco_lut (params LUTBITS, SINBITS; two registered read ports), contents generated at elaboration from REQ-016.
REQ-029 SHALL keep default widths in a shared package/header reused by the IQ modulator and demodulator blocks so sin/cos widths match.

Verification
REQ-030 SHALL test reset: rst_i pulsed mid-run at freq_i=2^28 -> sin_o=cos_o=0, wrap_o=0 immediately; sequence restarts from phase 0 three edges after release.
REQ-031 SHALL test quarter steps: defaults, sync_i one cycle then freq_i=2^30, phase_i=0 -> sin_o 3,8191,-3,-8191 repeating; cos_o 8191,-3,-8191,3; wrap_o once per 4 cycles.
REQ-032 SHALL test phase offset: freq_i=0, sync_i high, phase_i=2^31 -> sin_o=-3, cos_o=-8191 constant, wrap_o=0.
REQ-033 SHALL test wrap: freq_i=2^31+1 -> wrap_o on consecutive cycles per carry model; freq_i=0xFFFFFFFF -> wrap_o high every cycle after first.
REQ-034 SHALL test sync/increment collision: sync_i high with freq_i=2^30 -> acc=0 next edge, no wrap_o, outputs at 3 edges = (3,8191).
REQ-035 SHALL test sweep: freq_i=12345 for 10^6 cycles vs floating-point model -> |error| <= 1 LSB + truncation bound, sin^2+cos^2 within 0.1% of 8191^2, never -8192.
